core_mem_arbiter: RTL and testbench
===================================

# core_mem_arbiter

Two-port-to-one memory arbiter that shares a single unified memory port between the instruction-fetch requester and the load-store requester of the core. It sits between the core's fetch and load-store interfaces and the memory, with one transaction outstanding at a time. Load-store has priority, bounded by a fetch anti-starvation counter. A response timeout guarantees neither pipeline stage can hang on a dead memory.

## Interface
- XLEN, 32, address/data width
- STARVE_LIMIT, 4, consecutive contended load-store grants after which fetch wins the next contention (>=1)
- TIMEOUT, 16, cycles after a grant without mem_rvalid before an error response is generated (>=2)

- clk  in  1  core clock; everything on rising edge
- rstn  in  1  asynchronous active-low reset
- if_req / if_addr  in  1 / XLEN  fetch request, word address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid / if_rdata / if_addr_err  out  1 / XLEN / 1  fetch response
- ls_req / ls_we / ls_size / ls_addr / ls_wdata  in  1 / 1 / 2 / XLEN / XLEN  load-store request; size 0=byte, 1=half, 2=word
- ls_gnt  out  1  load-store request accepted
- ls_rvalid / ls_rdata / ls_addr_err  out  1 / XLEN / 1  load-store response; also acknowledges writes
- mem_req / mem_we / mem_size / mem_addr / mem_wdata  out  1 / 1 / 2 / XLEN / XLEN  memory request
- mem_rvalid / mem_rdata / mem_addr_err  in  1 / XLEN / 1  memory response; exactly one per mem_req, reads and writes

## Operation
- States: IDLE, WAIT_IF, WAIT_LS. Internal counters: starve_cnt (0..STARVE_LIMIT) and wait_cnt (0..TIMEOUT).
- Port is free when state is IDLE, or in WAIT_x in the cycle mem_rvalid=1 or the timeout fires. Free means arbitration happens this cycle, so back-to-back grants have zero bubble.
- Arbitration, combinational, only when free:
  - Only one requester: it wins.
  - Both requesting: LS wins unless starve_cnt==STARVE_LIMIT, in which case IF wins.
- On a grant: the winner's gnt=1 and mem_req=1. The mem_* fields are driven from the winner's inputs (IF drives mem_we=0, mem_size=2, mem_wdata=0). Next state is WAIT_IF or WAIT_LS. wait_cnt is cleared to 0.
- When not granting: mem_req=0, both gnt=0, and mem_we/mem_size/mem_addr/mem_wdata=0.
- starve_cnt update:
  - LS granted while if_req=1: increment, saturating.
  - IF granted: clear to 0.
  - LS granted while if_req=0: clear to 0.
- In WAIT_x with mem_rvalid=1:
  - The owner's rvalid=1, rdata=mem_rdata, addr_err=mem_addr_err, all combinational pass-through.
  - The non-owner's response outputs are all 0.
- Timeout: in WAIT_x, wait_cnt increments each cycle without mem_rvalid. When wait_cnt==TIMEOUT-1 and mem_rvalid=0:
  - The owner gets rvalid=1, addr_err=1, rdata=0.
  - The port is free in that cycle.
  - A memory response arriving after a timeout is a protocol violation and its attribution is undefined.
- mem_rvalid in IDLE is ignored: no rvalid to either side.
- Requesters hold req and fields stable until gnt. The arbiter never grants a requester whose response is still pending.

## Timing
- Reset (rstn low, asynchronously): state=IDLE, starve_cnt=0, wait_cnt=0. All outputs are forced to 0 while rstn=0, including the combinational gnt, mem_req and rvalid paths.
- Reset in the middle of a transaction abandons it. No rvalid is ever produced for it, even if mem_rvalid arrives after reset.
- Grant latency: 0 cycles (same cycle as req when free).
- Response latency equals memory latency. With a memory of latency L (1<=L<TIMEOUT), mem_rvalid arrives L cycles after the grant and rvalid appears in that same cycle.
- Sustained throughput is 1 transaction per L cycles. There is no dead cycle between transactions.
- Timeout response occurs exactly TIMEOUT cycles after the grant cycle.
- A simultaneous mem_rvalid and timeout cycle is treated as a normal response (no error injected).

## Test plan
- Single fetch, memory L=1: if_req=1, if_addr=0x100 at cycle 0 -> if_gnt=1 and mem_req=1, mem_addr=0x100, mem_we=0, mem_size=2 in cycle 0. mem_rdata=0xDEADBEEF in cycle 1 -> if_rvalid=1, if_rdata=0xDEADBEEF in cycle 1; ls_rvalid=0.
- Contention, L=1, STARVE_LIMIT=4, if_req and ls_req held high -> grant sequence LS,LS,LS,LS,IF,LS,LS,LS,LS,IF with no idle cycle between grants.
- Store: ls_we=1, ls_size=0, ls_addr=0x2003, ls_wdata=0xAB, L=3 -> mem_we=1, mem_size=0 in the grant cycle; ls_rvalid=1 three cycles later. A fetch raised the cycle after the grant gets if_gnt only in the ls_rvalid cycle.
- Timeout, TIMEOUT=16: grant LS, memory silent -> ls_rvalid=1, ls_addr_err=1, ls_rdata=0 exactly 16 cycles after the grant. A pending if_req is granted in that same cycle.
- Error pass-through: mem_addr_err=1 with the response -> the owner's addr_err=1 and the other side stays 0.
- Reset mid-transaction: grant IF, drop rstn for 2 cycles, then mem_rvalid arrives -> all outputs 0 during reset, no if_rvalid afterwards, and starve_cnt restarts from 0.

Source files
------------

// File: rtl/core_mem_arbiter.sv
// Shares one memory port between instruction fetch and load-store, one transaction in flight.
// Load-store has priority, bounded by a fetch anti-starvation counter and a response timeout.
module core_mem_arbiter #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 16
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [XLEN-1:0] if_rdata,
    output logic            if_addr_err,
    input  logic            ls_req,
    input  logic            ls_we,
    input  logic [1:0]      ls_size,
    input  logic [XLEN-1:0] ls_addr,
    input  logic [XLEN-1:0] ls_wdata,
    output logic            ls_gnt,
    output logic            ls_rvalid,
    output logic [XLEN-1:0] ls_rdata,
    output logic            ls_addr_err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [1:0]      mem_size,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_addr_err
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StWaitIf, StWaitLs} state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   starve_cnt_q, starve_cnt_d;
    logic [WW-1:0]   wait_cnt_q, wait_cnt_d;

    logic            in_wait, timeout, rsp_valid, free, grant_if, grant_ls;
    logic [XLEN-1:0] rsp_data;
    logic            rsp_err;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= StIdle;
            starve_cnt_q <= '0;
            wait_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        if_gnt       = 1'b0;
        if_rvalid    = 1'b0;
        if_rdata     = '0;
        if_addr_err  = 1'b0;
        ls_gnt       = 1'b0;
        ls_rvalid    = 1'b0;
        ls_rdata     = '0;
        ls_addr_err  = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_size     = 2'd0;
        mem_addr     = '0;
        mem_wdata    = '0;
        grant_if     = 1'b0;
        grant_ls     = 1'b0;

        in_wait   = (state_q != StIdle);
        // A real response in the timeout cycle wins over the synthesized error.
        timeout   = in_wait && !mem_rvalid && (wait_cnt_q == WW'(TIMEOUT - 1));
        rsp_valid = in_wait && (mem_rvalid || timeout);
        rsp_data  = mem_rvalid ? mem_rdata : '0;
        rsp_err   = mem_rvalid ? mem_addr_err : 1'b1;
        free      = !in_wait || rsp_valid;

        if (in_wait) begin
            if (rsp_valid) begin
                state_d    = StIdle;
                wait_cnt_d = '0;
            end else if (wait_cnt_q != WW'(TIMEOUT)) begin
                wait_cnt_d = wait_cnt_q + WW'(1);
            end
        end

        if (state_q == StWaitIf) begin
            if_rvalid   = rsp_valid;
            if_rdata    = rsp_valid ? rsp_data : '0;
            if_addr_err = rsp_valid && rsp_err;
        end else if (state_q == StWaitLs) begin
            ls_rvalid   = rsp_valid;
            ls_rdata    = rsp_valid ? rsp_data : '0;
            ls_addr_err = rsp_valid && rsp_err;
        end

        if (free) begin
            grant_ls = ls_req && (!if_req || (starve_cnt_q != SW'(STARVE_LIMIT)));
            grant_if = if_req && !grant_ls;
        end

        if (grant_ls) begin
            ls_gnt     = 1'b1;
            mem_req    = 1'b1;
            mem_we     = ls_we;
            mem_size   = ls_size;
            mem_addr   = ls_addr;
            mem_wdata  = ls_wdata;
            state_d    = StWaitLs;
            wait_cnt_d = '0;
            if (!if_req) begin
                starve_cnt_d = '0;
            end else if (starve_cnt_q != SW'(STARVE_LIMIT)) begin
                starve_cnt_d = starve_cnt_q + SW'(1);
            end
        end else if (grant_if) begin
            if_gnt       = 1'b1;
            mem_req      = 1'b1;
            mem_size     = 2'd2;
            mem_addr     = if_addr;
            state_d      = StWaitIf;
            wait_cnt_d   = '0;
            starve_cnt_d = '0;
        end

        // Combinational paths must also be silent while reset is held.
        if (!rstn) begin
            if_gnt      = 1'b0;
            if_rvalid   = 1'b0;
            if_rdata    = '0;
            if_addr_err = 1'b0;
            ls_gnt      = 1'b0;
            ls_rvalid   = 1'b0;
            ls_rdata    = '0;
            ls_addr_err = 1'b0;
            mem_req     = 1'b0;
            mem_we      = 1'b0;
            mem_size    = 2'd0;
            mem_addr    = '0;
            mem_wdata   = '0;
        end
    end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Scoreboard bench for core_mem_arbiter: stimulus queues expected grants/responses with
// their cycle numbers, a negedge monitor pops and compares whatever the DUT presents.
module tb_core_mem_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        if_req, ls_req, ls_we;
    logic [31:0] if_addr, ls_addr, ls_wdata;
    logic [1:0]  ls_size;
    logic        if_gnt, if_rvalid, if_addr_err, ls_gnt, ls_rvalid, ls_addr_err;
    logic [31:0] if_rdata, ls_rdata;
    logic        mem_req, mem_we;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_rvalid, mem_addr_err;
    logic [31:0] mem_rdata;

    int          mem_lat;
    logic        mem_silent, mem_err_next;
    int          cyc = 0;
    logic        done = 1'b0;
    int          ncmp = 0;
    int          nfail = 0;

    typedef struct {
        logic        who;  // 1 = load-store
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          cyc;
    } gnt_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } rsp_t;

    gnt_t gq[$];
    rsp_t ifq[$];
    rsp_t lsq[$];

    core_mem_arbiter #(.XLEN(32), .STARVE_LIMIT(4), .TIMEOUT(16)) dut (
        .clk(clk), .rstn(rstn),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_addr_err(if_addr_err),
        .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_gnt(ls_gnt),
        .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_addr_err(ls_addr_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_addr_err(mem_addr_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory: response L cycles after the grant, data = addr + 0xDEADBDEF.
    initial begin
        logic        pend;
        int          pend_cnt;
        logic [31:0] pend_addr;
        logic        pend_err;
        pend = 1'b0; pend_cnt = 0; pend_addr = '0; pend_err = 1'b0;
        mem_rvalid = 1'b0; mem_rdata = '0; mem_addr_err = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_req && !mem_silent) begin
                pend = 1'b1; pend_cnt = mem_lat; pend_addr = mem_addr; pend_err = mem_err_next;
            end
            @(posedge clk);
            #1;
            mem_rvalid = 1'b0; mem_rdata = '0; mem_addr_err = 1'b0;
            if (pend) begin
                pend_cnt = pend_cnt - 1;
                if (pend_cnt == 0) begin
                    pend = 1'b0;
                    mem_rvalid = 1'b1;
                    mem_rdata = pend_addr + 32'hDEAD_BDEF;
                    mem_addr_err = pend_err;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        gnt_t g;
        rsp_t r;
        if (!rstn) begin
            chk("reset_outputs_zero",
                {if_gnt, if_rvalid, if_rdata, if_addr_err, ls_gnt, ls_rvalid, ls_rdata,
                 ls_addr_err, mem_req, mem_we, mem_size, mem_addr, mem_wdata}, '0);
        end else begin
            chk("gnt_mutex", 128'(if_gnt & ls_gnt), '0);
            chk("mem_req_vs_gnt", 128'(mem_req), 128'(if_gnt | ls_gnt));
            if (if_gnt || ls_gnt) begin
                if (gq.size() == 0) chk("unexpected_gnt", {if_gnt, ls_gnt}, '0);
                else begin
                    g = gq.pop_front();
                    chk("gnt", {ls_gnt, mem_we, mem_size, mem_addr, mem_wdata, cyc},
                        {g.who, g.we, g.size, g.addr, g.wdata, g.cyc});
                end
            end else if (gq.size() > 0 && gq[0].cyc <= cyc) begin
                g = gq.pop_front();
                chk("missing_gnt", {if_gnt, ls_gnt}, {~g.who, g.who});
            end
            if (if_rvalid) begin
                if (ifq.size() == 0) chk("unexpected_if_rvalid", 128'(if_rvalid), '0);
                else begin
                    r = ifq.pop_front();
                    chk("if_rsp", {if_rdata, if_addr_err, cyc}, {r.data, r.err, r.cyc});
                end
            end else if (ifq.size() > 0 && ifq[0].cyc <= cyc) begin
                void'(ifq.pop_front());
                chk("missing_if_rsp", 128'(if_rvalid), 128'(1));
            end
            if (ls_rvalid) begin
                if (lsq.size() == 0) chk("unexpected_ls_rvalid", 128'(ls_rvalid), '0);
                else begin
                    r = lsq.pop_front();
                    chk("ls_rsp", {ls_rdata, ls_addr_err, cyc}, {r.data, r.err, r.cyc});
                end
            end else if (lsq.size() > 0 && lsq[0].cyc <= cyc) begin
                void'(lsq.pop_front());
                chk("missing_ls_rsp", 128'(ls_rvalid), 128'(1));
            end
        end
        if (done) begin
            chk("leftover_expectations", 128'(gq.size() + ifq.size() + lsq.size()), '0);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
            $finish;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_gnt(input logic who, input logic [31:0] addr, input logic we,
                           input logic [1:0] size, input logic [31:0] wdata, input int c);
        gnt_t g;
        g.who = who; g.addr = addr; g.we = we; g.size = size; g.wdata = wdata; g.cyc = c;
        gq.push_back(g);
    endtask

    task automatic exp_rsp(input logic who, input logic [31:0] data, input logic err,
                           input int c);
        rsp_t r;
        r.data = data; r.err = err; r.cyc = c;
        if (who) lsq.push_back(r);
        else ifq.push_back(r);
    endtask

    initial begin
        int c;
        rstn = 1'b0;
        if_req = 0; if_addr = '0; ls_req = 0; ls_we = 0; ls_size = 2'd2; ls_addr = '0;
        ls_wdata = '0; mem_lat = 1; mem_silent = 0; mem_err_next = 0;
        repeat (2) tick();
        rstn = 1'b1;

        // Single fetch, L=1
        c = cyc;
        if_req = 1; if_addr = 32'h100;
        exp_gnt(0, 32'h100, 0, 2'd2, 0, c);
        exp_rsp(0, 32'hDEAD_BEEF, 0, c + 1);
        tick(); if_req = 0;
        repeat (2) tick();

        // Contention with both held: LS x4, IF, LS x4, IF
        c = cyc;
        if_req = 1; if_addr = 32'h400;
        ls_req = 1; ls_we = 0; ls_size = 2'd2; ls_addr = 32'h800; ls_wdata = 0;
        for (int k = 0; k < 10; k++) begin
            if (k == 4 || k == 9) begin
                exp_gnt(0, 32'h400, 0, 2'd2, 0, c + k);
                exp_rsp(0, 32'hDEAD_C1EF, 0, c + k + 1);
            end else begin
                exp_gnt(1, 32'h800, 0, 2'd2, 0, c + k);
                exp_rsp(1, 32'hDEAD_C5EF, 0, c + k + 1);
            end
        end
        repeat (10) tick();
        if_req = 0; ls_req = 0;
        repeat (2) tick();

        // Byte store, L=3; fetch raised next cycle waits for the store response
        mem_lat = 3;
        c = cyc;
        ls_req = 1; ls_we = 1; ls_size = 2'd0; ls_addr = 32'h2003; ls_wdata = 32'hAB;
        exp_gnt(1, 32'h2003, 1, 2'd0, 32'hAB, c);
        exp_rsp(1, 32'hDEAD_DDF2, 0, c + 3);
        tick();
        ls_req = 0; ls_we = 0; ls_size = 2'd2; ls_wdata = 0;
        if_req = 1; if_addr = 32'h300;
        exp_gnt(0, 32'h300, 0, 2'd2, 0, c + 3);
        exp_rsp(0, 32'hDEAD_C0EF, 0, c + 6);
        repeat (3) tick();
        if_req = 0;
        repeat (3) tick();

        // Timeout on a silent memory; pending fetch granted in the timeout cycle
        mem_lat = 1; mem_silent = 1;
        c = cyc;
        ls_req = 1; ls_addr = 32'h500;
        exp_gnt(1, 32'h500, 0, 2'd2, 0, c);
        exp_rsp(1, 32'h0, 1, c + 16);
        tick();
        ls_req = 0; mem_silent = 0;
        if_req = 1; if_addr = 32'h600;
        exp_gnt(0, 32'h600, 0, 2'd2, 0, c + 16);
        exp_rsp(0, 32'hDEAD_C3EF, 0, c + 17);
        repeat (16) tick();
        if_req = 0;
        repeat (2) tick();

        // Error pass-through, L=2
        mem_lat = 2; mem_err_next = 1;
        c = cyc;
        ls_req = 1; ls_addr = 32'h700;
        exp_gnt(1, 32'h700, 0, 2'd2, 0, c);
        exp_rsp(1, 32'hDEAD_C4EF, 1, c + 2);
        tick();
        ls_req = 0; mem_err_next = 0;
        repeat (3) tick();

        // Reset during an outstanding fetch; late memory response must be dropped
        mem_lat = 4;
        c = cyc;
        if_req = 1; if_addr = 32'h900;
        exp_gnt(0, 32'h900, 0, 2'd2, 0, c);
        tick();
        rstn = 0; ls_req = 1; ls_addr = 32'h800;
        repeat (2) tick();
        if_req = 0; ls_req = 0; if_addr = 32'h400; rstn = 1;
        repeat (4) tick();

        // Starvation counter restarts after reset: 3 LS grants, reset, then LS x4, IF
        mem_lat = 1;
        c = cyc;
        if_req = 1; ls_req = 1;
        for (int k = 0; k < 3; k++) exp_gnt(1, 32'h800, 0, 2'd2, 0, c + k);
        exp_rsp(1, 32'hDEAD_C5EF, 0, c + 1);
        exp_rsp(1, 32'hDEAD_C5EF, 0, c + 2);
        repeat (3) tick();
        rstn = 0;
        repeat (2) tick();
        rstn = 1;
        for (int k = 5; k < 9; k++) begin
            exp_gnt(1, 32'h800, 0, 2'd2, 0, c + k);
            exp_rsp(1, 32'hDEAD_C5EF, 0, c + k + 1);
        end
        exp_gnt(0, 32'h400, 0, 2'd2, 0, c + 9);
        exp_rsp(0, 32'hDEAD_C1EF, 0, c + 10);
        repeat (5) tick();
        if_req = 0; ls_req = 0;
        repeat (2) tick();

        done = 1'b1;
    end

endmodule
